// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - screen RAM scanout: read address generation, RRRGGGBB to 4:4:4 conversion, sync alignment
module fb_scanout #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int FB_W   = 320,
    parameter int FB_H   = 200,
    parameter int Y_OFF  = 40,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        border,
    input  logic [9:0]        posx,
    input  logic [9:0]        posy,
    input  logic              hsync_i,
    input  logic              vsync_i,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [3:0]        r_o,
    output logic [3:0]        g_o,
    output logic [3:0]        b_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              frame_done
);
    localparam int DS = RD_LAT + 1;
    localparam logic [9:0] H_ACT_V  = 10'(H_ACT);
    localparam logic [9:0] H_LAST_V = 10'(H_ACT - 1);
    localparam logic [9:0] V_ACT_V  = 10'(V_ACT);
    localparam logic [9:0] V_LAST_V = 10'(V_ACT - 1);
    localparam logic [9:0] Y_OFF_V  = 10'(Y_OFF);
    localparam logic [9:0] Y_END_V  = 10'(Y_OFF + 2 * FB_H);
    localparam logic       Y_OFF_ODD = 1'(Y_OFF % 2);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_RUN} state_t;

    state_t state, state_nxt;
    logic   run_eff;

    logic frame_start, vis, in_win, is_fb, is_border, last_px, row_odd;
    logic [ADDR_W-1:0] line_base, col;

    logic [DS-1:0] p_fb, p_bd, p_run, p_done, p_hs, p_vs;
    logic [7:0]    pix;
    logic          pix_on;

    assign frame_start = (posx == 10'd0) && (posy == 10'd0);
    assign vis         = (posx < H_ACT_V) && (posy < V_ACT_V);
    assign in_win      = (posy >= Y_OFF_V) && (posy < Y_END_V);
    assign is_fb       = vis && in_win;
    assign is_border   = vis && !in_win;
    assign last_px     = (posx == H_LAST_V) && (posy == V_LAST_V);
    assign row_odd     = posy[0] ^ Y_OFF_ODD;
    assign col         = {{(ADDR_W-9){1'b0}}, posx[9:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_OFF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   if (enable) state_nxt = S_ARMED;
            S_ARMED: if (!enable) state_nxt = S_OFF;
                     else if (frame_start) state_nxt = S_RUN;
            S_RUN:   if (frame_start && !enable) state_nxt = S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    // The sample taken on the frame-start cycle already belongs to the new frame's mode.
    always_comb begin
        run_eff = (state_nxt == S_RUN);
    end

    // Each framebuffer row is shown on two lines, so the base advances after every second one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            rd_addr   <= '0;
        end else begin
            if (frame_start)
                line_base <= '0;
            else if (posx == H_ACT_V && in_win && row_odd)
                line_base <= line_base + FB_W_A;
            if (is_fb)
                rd_addr <= line_base + col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_fb   <= '0;
            p_bd   <= '0;
            p_run  <= '0;
            p_done <= '0;
            p_hs   <= '1;
            p_vs   <= '1;
        end else begin
            p_fb[0]   <= is_fb;
            p_bd[0]   <= is_border;
            p_run[0]  <= run_eff;
            p_done[0] <= run_eff && last_px;
            p_hs[0]   <= hsync_i;
            p_vs[0]   <= vsync_i;
            for (int i = 1; i < DS; i++) begin
                p_fb[i]   <= p_fb[i-1];
                p_bd[i]   <= p_bd[i-1];
                p_run[i]  <= p_run[i-1];
                p_done[i] <= p_done[i-1];
                p_hs[i]   <= p_hs[i-1];
                p_vs[i]   <= p_vs[i-1];
            end
        end
    end

    always_comb begin
        pix    = border;
        pix_on = 1'b0;
        if (p_run[DS-1]) begin
            if (p_fb[DS-1]) begin
                pix    = rd_data;
                pix_on = 1'b1;
            end else if (p_bd[DS-1]) begin
                pix_on = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o        <= 4'd0;
            g_o        <= 4'd0;
            b_o        <= 4'd0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            hsync_o    <= p_hs[DS-1];
            vsync_o    <= p_vs[DS-1];
            frame_done <= p_done[DS-1];
            if (pix_on) begin
                r_o <= {pix[7:5], pix[7]};
                g_o <= {pix[4:2], pix[4]};
                b_o <= {pix[1:0], pix[1:0]};
            end else begin
                r_o <= 4'd0;
                g_o <= 4'd0;
                b_o <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - scoreboard bench for fb_scanout against a frame-level reference model
module tb_fb_scanout;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  border = 8'h00;
    logic [9:0]  posx = 10'd700;
    logic [9:0]  posy = 10'd500;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [3:0]  r_o, g_o, b_o;
    logic        hsync_o, vsync_o, frame_done;

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk(clk), .rst(rst), .enable(enable), .border(border),
        .posx(posx), .posy(posy), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_done(frame_done)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int due; logic [15:0] addr; } addr_exp_t;
    typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; logic done; int x; int y; } out_exp_t;
    addr_exp_t addr_q[$];
    out_exp_t  out_q[$];

    localparam int M_OFF = 0, M_ARMED = 1, M_RUN = 2;
    int          mst = M_OFF;
    logic [15:0] maddr = 16'd0;
    logic        en_next = 1'b0;

    function automatic logic [11:0] conv(input logic [7:0] p);
        return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sample per cycle; the reference derives the expected response from the screen geometry.
    task automatic drive(input int x, input int y);
        logic vis, fb, fs;
        logic [11:0] rgb;
        @(negedge clk);
        enable  = en_next;
        posx    = 10'(x);
        posy    = 10'(y);
        hsync_i = !(x >= 656 && x < 752);
        vsync_i = !(y >= 490 && y < 492);
        fs = (x == 0 && y == 0);
        case (mst)
            M_OFF:   if (en_next) mst = M_ARMED;
            M_ARMED: if (!en_next) mst = M_OFF; else if (fs) mst = M_RUN;
            default: if (fs && !en_next) mst = M_OFF;
        endcase
        vis = (x < 640) && (y < 480);
        fb  = vis && (y >= 40) && (y < 440);
        if (fb) maddr = 16'(((y - 40) / 2) * 320 + x / 2);
        addr_q.push_back('{cyc + 1, maddr});
        rgb = 12'h000;
        if (mst == M_RUN && vis) rgb = fb ? conv(mem[maddr]) : conv(border);
        out_q.push_back('{cyc + 3, rgb, hsync_i, vsync_i, (mst == M_RUN && x == 639 && y == 479), x, y});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset colour", 32'({r_o, g_o, b_o}), 32'd0);
        check("reset hsync_o", 32'(hsync_o), 32'd1);
        check("reset vsync_o", 32'(vsync_o), 32'd1);
        check("reset frame_done", 32'(frame_done), 32'd0);
        addr_q.delete();
        out_q.delete();
        mst   = M_OFF;
        maddr = 16'd0;
        posx  = 10'd700;
        posy  = 10'd500;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Compressed scan: a handful of samples per line, always crossing posx==640 exactly once.
    task automatic frame(input int kill_y, input int toggle_y, input int sweep_y, input int stop_y, input int stop_x);
        for (int y = 0; y < 525; y++) begin
            if (y == stop_y) begin
                for (int x = 0; x <= stop_x; x++) drive(x, y);
                return;
            end
            if (y == sweep_y) begin
                for (int x = 0; x < 800; x++) drive(x, y);
            end else begin
                drive(0, y);
                drive(1, y);
                drive(10, y);
                drive(int'($urandom_range(319, 11)), y);
                if (y == kill_y || y == toggle_y) en_next = 1'b0;
                drive(320, y);
                drive(int'($urandom_range(638, 321)), y);
                if (y == toggle_y) en_next = 1'b1;
                drive(639, y);
                drive(640, y);
                drive(700, y);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        addr_exp_t a;
        out_exp_t  o;
        if (!rst) begin
            while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                a = addr_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(a.addr));
            end
            while (out_q.size() > 0 && out_q[0].due <= cyc) begin
                o = out_q.pop_front();
                check($sformatf("colour(%0d,%0d)", o.x, o.y), 32'({r_o, g_o, b_o}), 32'(o.rgb));
                check($sformatf("hsync_o(%0d,%0d)", o.x, o.y), 32'(hsync_o), 32'(o.hs));
                check($sformatf("vsync_o(%0d,%0d)", o.x, o.y), 32'(vsync_o), 32'(o.vs));
                check($sformatf("frame_done(%0d,%0d)", o.x, o.y), 32'(frame_done), 32'(o.done));
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0]     = 8'hE0;
        mem[325]   = 8'h1C;
        mem[63999] = 8'h03;
        mem[5]     = 8'h49;

        repeat (3) @(negedge clk);
        check("init rd_addr", 32'(rd_addr), 32'd0);
        check("init colour", 32'({r_o, g_o, b_o}), 32'd0);
        check("init hsync_o", 32'(hsync_o), 32'd1);
        check("init vsync_o", 32'(vsync_o), 32'd1);
        check("init frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int x = 0; x < 800; x++) drive(x, 5);

        en_next = 1'b1;
        border  = 8'($urandom);
        frame(-1, -1, -1, -1, 0);
        border  = 8'hFF;
        frame(-1, 300, 100, -1, 0);
        border  = 8'($urandom);
        frame(200, -1, -1, -1, 0);
        frame(-1, -1, -1, 250, 700);
        do_reset();

        en_next = 1'b1;
        frame(-1, -1, -1, -1, 0);
        frame(-1, -1, -1, 100, 300);
        do_reset();

        for (int i = 0; i < 6; i++) drive(700, 500);
        repeat (5) @(negedge clk);
        n_checks++;
        if (addr_q.size() != 0 || out_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d addr and %0d output expectations left, required 0", addr_q.size(), out_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
